// File: rtl/scariv_age_issue_queue.sv
// Out-of-order issue queue: tag wakeup, per-cycle multi-dispatch and multi-issue.
// Define SCARIV_ISSUE_OLDEST_EN to pick oldest-first from an age matrix; otherwise lowest index wins.
module scariv_age_issue_queue #(
    parameter int ENTRY_SIZE    = 16,
    parameter int IN_PORT_SIZE  = 2,
    parameter int ISS_PORT_SIZE = 2,
    parameter int WAKE_PORTS    = 2,
    parameter int TAG_W         = 7,
    parameter int PAYLOAD_W     = 64
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset_n,
    input  logic [IN_PORT_SIZE-1:0]                       i_disp_valid,
    input  logic [IN_PORT_SIZE-1:0][PAYLOAD_W-1:0]        i_disp_payload,
    input  logic [IN_PORT_SIZE-1:0][1:0][TAG_W-1:0]       i_disp_rs_tag,
    input  logic [IN_PORT_SIZE-1:0][1:0]                  i_disp_rs_ready,
    input  logic [WAKE_PORTS-1:0]                         i_wake_valid,
    input  logic [WAKE_PORTS-1:0][TAG_W-1:0]              i_wake_tag,
    input  logic                                          i_stall,
    input  logic                                          i_flush,
    output logic [ISS_PORT_SIZE-1:0]                      o_iss_valid,
    output logic [ISS_PORT_SIZE-1:0][PAYLOAD_W-1:0]       o_iss_payload,
    output logic [ISS_PORT_SIZE-1:0][ENTRY_SIZE-1:0]      o_iss_index_oh,
    output logic [$clog2(ENTRY_SIZE):0]                   o_free_cnt
);

    localparam int CNT_W = $clog2(ENTRY_SIZE) + 1;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_ISSUED} entry_state_e;

    entry_state_e                               state_q [ENTRY_SIZE];
    entry_state_e                               state_d [ENTRY_SIZE];
    logic [ENTRY_SIZE-1:0][1:0]                 rdy_q, rdy_d;
    logic [ENTRY_SIZE-1:0][1:0][TAG_W-1:0]      tag_q;
    logic [ENTRY_SIZE-1:0][PAYLOAD_W-1:0]       payload_q;

    logic [ENTRY_SIZE-1:0]                      free_vec, eligible, disp_we, issued_vec;
    logic [IN_PORT_SIZE-1:0][ENTRY_SIZE-1:0]    slot_oh;
    logic [IN_PORT_SIZE-1:0]                    slot_found;
    logic [ISS_PORT_SIZE-1:0][ENTRY_SIZE-1:0]   pick_oh;
    logic [CNT_W-1:0]                           free_cnt_d;

    function automatic logic wake_hit(input logic [WAKE_PORTS-1:0]            vld,
                                      input logic [WAKE_PORTS-1:0][TAG_W-1:0] tags,
                                      input logic [TAG_W-1:0]                 tag);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKE_PORTS; w++) hit |= vld[w] && (tags[w] == tag);
        return hit;
    endfunction

    // Eligibility looks only at registered state, so wakeups take effect one cycle later.
    always_comb begin
        for (int e = 0; e < ENTRY_SIZE; e++) begin
            free_vec[e] = (state_q[e] == ST_FREE);
            eligible[e] = (state_q[e] == ST_WAIT) && (&rdy_q[e]);
        end
    end

    // NOTE: every always_comb output gets a default before any conditional write, so no latches form.
    always_comb begin
        logic [ENTRY_SIZE-1:0] avail;
        avail   = free_vec;
        disp_we = '0;
        for (int p = 0; p < IN_PORT_SIZE; p++) begin
            slot_oh[p]    = avail & (~avail + ENTRY_SIZE'(1));
            slot_found[p] = |slot_oh[p];
            avail         = avail & ~slot_oh[p];
            if (i_disp_valid[p] && !i_flush) disp_we = disp_we | slot_oh[p];
        end
    end

    // Ready bits fold in same-cycle wakeups, including for entries dispatched this cycle.
    always_comb begin
        for (int e = 0; e < ENTRY_SIZE; e++)
            for (int s = 0; s < 2; s++)
                rdy_d[e][s] = rdy_q[e][s] | wake_hit(i_wake_valid, i_wake_tag, tag_q[e][s]);
        for (int p = 0; p < IN_PORT_SIZE; p++)
            for (int e = 0; e < ENTRY_SIZE; e++)
                if (i_disp_valid[p] && slot_oh[p][e])
                    for (int s = 0; s < 2; s++)
                        rdy_d[e][s] = i_disp_rs_ready[p][s]
                                    | wake_hit(i_wake_valid, i_wake_tag, i_disp_rs_tag[p][s]);
    end

`ifdef SCARIV_ISSUE_OLDEST_EN
    // age_q[j][e] set means entry j is older than entry e.
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] age_q, age_d;

    always_comb begin
        logic [ENTRY_SIZE-1:0] elder;
        for (int e = 0; e < ENTRY_SIZE; e++) elder[e] = (state_q[e] != ST_FREE);
        age_d = age_q;
        for (int p = 0; p < IN_PORT_SIZE; p++) begin
            if (i_disp_valid[p] && !i_flush) begin
                for (int e = 0; e < ENTRY_SIZE; e++) begin
                    if (slot_oh[p][e]) begin
                        age_d[e] = '0;
                        for (int j = 0; j < ENTRY_SIZE; j++)
                            if (elder[j]) age_d[j][e] = 1'b1;
                    end
                end
                elder = elder | slot_oh[p];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) age_q <= '0;
        else            age_q <= age_d;
    end

    always_comb begin
        logic [ENTRY_SIZE-1:0] remain;
        logic                  older_pending;
        remain = eligible;
        for (int k = 0; k < ISS_PORT_SIZE; k++) begin
            pick_oh[k] = '0;
            for (int e = 0; e < ENTRY_SIZE; e++) begin
                older_pending = 1'b0;
                for (int j = 0; j < ENTRY_SIZE; j++) older_pending |= remain[j] & age_q[j][e];
                pick_oh[k][e] = remain[e] & ~older_pending;
            end
            remain = remain & ~pick_oh[k];
        end
    end
`else
    always_comb begin
        logic [ENTRY_SIZE-1:0] remain;
        remain = eligible;
        for (int k = 0; k < ISS_PORT_SIZE; k++) begin
            pick_oh[k] = remain & (~remain + ENTRY_SIZE'(1));
            remain     = remain & ~pick_oh[k];
        end
    end
`endif

    always_comb begin
        issued_vec = '0;
        for (int k = 0; k < ISS_PORT_SIZE; k++) begin
            o_iss_valid[k]    = 1'b0;
            o_iss_index_oh[k] = '0;
            o_iss_payload[k]  = '0;
            if (!i_stall && (pick_oh[k] != '0)) begin
                o_iss_valid[k]    = 1'b1;
                o_iss_index_oh[k] = pick_oh[k];
                for (int e = 0; e < ENTRY_SIZE; e++)
                    if (pick_oh[k][e]) o_iss_payload[k] = payload_q[e];
            end
            issued_vec = issued_vec | o_iss_index_oh[k];
        end
    end

    // Flush overrides dispatch and issue; free count is taken from the next state so same-cycle moves net out.
    always_comb begin
        logic [CNT_W-1:0] busy_cnt;
        busy_cnt = '0;
        for (int e = 0; e < ENTRY_SIZE; e++) begin
            state_d[e] = state_q[e];
            if (i_flush) begin
                state_d[e] = ST_FREE;
            end else begin
                case (state_q[e])
                    ST_FREE:   if (disp_we[e])    state_d[e] = ST_WAIT;
                    ST_WAIT:   if (issued_vec[e]) state_d[e] = ST_ISSUED;
                    ST_ISSUED: state_d[e] = ST_FREE;
                    default:   state_d[e] = ST_FREE;
                endcase
            end
            busy_cnt = busy_cnt + CNT_W'(state_d[e] != ST_FREE);
        end
        free_cnt_d = CNT_W'(ENTRY_SIZE) - busy_cnt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int e = 0; e < ENTRY_SIZE; e++) state_q[e] <= ST_FREE;
            rdy_q      <= '0;
            o_free_cnt <= CNT_W'(ENTRY_SIZE);
        end else begin
            for (int e = 0; e < ENTRY_SIZE; e++) state_q[e] <= state_d[e];
            rdy_q      <= rdy_d;
            o_free_cnt <= free_cnt_d;
        end
    end

    // NOTE: payload and tag storage has no reset; a FREE entry's contents are never observed.
    always_ff @(posedge i_clk) begin
        for (int p = 0; p < IN_PORT_SIZE; p++) begin
            for (int e = 0; e < ENTRY_SIZE; e++) begin
                if (i_disp_valid[p] && !i_flush && slot_oh[p][e]) begin
                    payload_q[e] <= i_disp_payload[p];
                    tag_q[e]     <= i_disp_rs_tag[p];
                end
            end
        end
    end

    a_disp_credit: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                                    (i_disp_valid & ~slot_found) == '0);

endmodule

// File: tb/tb_scariv_age_issue_queue.sv
// Scoreboard bench for scariv_age_issue_queue: directed dispatch/wake/stall/flush/reset scenarios.
// Expected issue records are queued by the stimulus and checked by a negedge monitor.
module tb_scariv_age_issue_queue;

    localparam int ES = 16, IP = 2, IS = 2, WP = 2, TW = 7, PW = 64;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [IP-1:0]              disp_valid;
    logic [IP-1:0][PW-1:0]      disp_payload;
    logic [IP-1:0][1:0][TW-1:0] disp_rs_tag;
    logic [IP-1:0][1:0]         disp_rs_ready;
    logic [WP-1:0]              wake_valid;
    logic [WP-1:0][TW-1:0]      wake_tag;
    logic                       stall, flush;
    logic [IS-1:0]              iss_valid;
    logic [IS-1:0][PW-1:0]      iss_payload;
    logic [IS-1:0][ES-1:0]      iss_index_oh;
    logic [4:0]                 free_cnt;

    scariv_age_issue_queue #(
        .ENTRY_SIZE(ES), .IN_PORT_SIZE(IP), .ISS_PORT_SIZE(IS),
        .WAKE_PORTS(WP), .TAG_W(TW), .PAYLOAD_W(PW)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_disp_valid(disp_valid), .i_disp_payload(disp_payload),
        .i_disp_rs_tag(disp_rs_tag), .i_disp_rs_ready(disp_rs_ready),
        .i_wake_valid(wake_valid), .i_wake_tag(wake_tag),
        .i_stall(stall), .i_flush(flush),
        .o_iss_valid(iss_valid), .o_iss_payload(iss_payload),
        .o_iss_index_oh(iss_index_oh), .o_free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int          cyc;
        logic [1:0]  valid;
        logic [63:0] pl0, pl1;
        logic [15:0] oh0, oh1;
    } iss_t;

    iss_t sb[$];
    iss_t mon_rec;

    task automatic exp_iss(input int c, input int n, input logic [63:0] pl0, input int e0,
                           input logic [63:0] pl1, input int e1);
        iss_t r;
        r.cyc   = c;
        r.valid = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
        r.pl0   = (n > 0) ? pl0 : 64'd0;
        r.oh0   = (n > 0) ? (16'd1 << e0) : 16'd0;
        r.pl1   = (n > 1) ? pl1 : 64'd0;
        r.oh1   = (n > 1) ? (16'd1 << e1) : 16'd0;
        sb.push_back(r);
    endtask

    // Monitor: compare whenever a record is due, flag any issue nobody asked for.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("iss_missing_cycle", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_rec = sb.pop_front();
            check("iss_valid",    iss_valid,       mon_rec.valid);
            check("iss_payload0", iss_payload[0],  mon_rec.pl0);
            check("iss_index0",   iss_index_oh[0], mon_rec.oh0);
            check("iss_payload1", iss_payload[1],  mon_rec.pl1);
            check("iss_index1",   iss_index_oh[1], mon_rec.oh1);
        end else if (iss_valid != '0) begin
            check("iss_unexpected", iss_valid, 0);
        end
    end

    task automatic clear_inputs();
        disp_valid    = '0;
        disp_payload  = '0;
        disp_rs_tag   = '0;
        disp_rs_ready = '0;
        wake_valid    = '0;
        wake_tag      = '0;
        stall         = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic set_disp(input int p, input logic [63:0] pl, input logic [6:0] t1, input logic [6:0] t2,
                            input logic r1, input logic r2);
        disp_valid[p]       = 1'b1;
        disp_payload[p]     = pl;
        disp_rs_tag[p][0]   = t1;
        disp_rs_tag[p][1]   = t2;
        disp_rs_ready[p][0] = r1;
        disp_rs_ready[p][1] = r2;
    endtask

    task automatic set_wake(input int w, input logic [6:0] tag);
        wake_valid[w] = 1'b1;
        wake_tag[w]   = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_clr();
        step();
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_free_cnt", free_cnt, 16);
        check("rst_iss_valid", iss_valid, 0);
        check("rst_iss_index0", iss_index_oh[0], 0);
        rst_n = 1'b1;
        step();

        // Two ready ops issue together the next cycle, then credit returns two edges later.
        set_disp(0, 64'hA, 7'h01, 7'h02, 1'b1, 1'b1);
        set_disp(1, 64'hB, 7'h03, 7'h04, 1'b1, 1'b1);
        exp_iss(cyc + 1, 2, 64'hA, 0, 64'hB, 1);
        step_clr();
        check("ab_free_after_disp", free_cnt, 14);
        step();
        check("ab_free_while_issued", free_cnt, 14);
        step();
        check("ab_free_released", free_cnt, 16);

        // Wake two cycles after dispatch; issue exactly one cycle after the wake.
        set_disp(0, 64'hC, 7'h12, 7'h13, 1'b0, 1'b1);
        step_clr();
        step();
        set_wake(1, 7'h12);
        exp_iss(cyc + 1, 1, 64'hC, 0, 64'h0, 0);
        step_clr();
        step();
        step();
        check("c_free_released", free_cnt, 16);

        // Wake in the dispatch cycle is captured.
        set_disp(0, 64'hD, 7'h05, 7'h06, 1'b0, 1'b1);
        set_wake(0, 7'h05);
        exp_iss(cyc + 1, 1, 64'hD, 0, 64'h0, 0);
        step_clr();
        step();
        step();
        check("d_free_released", free_cnt, 16);

        // Stall holds eligible entries back for one cycle.
        set_disp(0, 64'hF0, 7'h01, 7'h02, 1'b1, 1'b1);
        set_disp(1, 64'hF1, 7'h01, 7'h02, 1'b1, 1'b1);
        exp_iss(cyc + 1, 0, 64'h0, 0, 64'h0, 0);
        exp_iss(cyc + 2, 2, 64'hF0, 0, 64'hF1, 1);
        step_clr();
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        step();
        check("stall_free_released", free_cnt, 16);

        // Fill the queue with waiting ops, then wake them all with one shared tag.
        for (int i = 0; i < 8; i++) begin
            set_disp(0, 64'h100 + 64'(2 * i),     7'h30, 7'h31, 1'b0, 1'b1);
            set_disp(1, 64'h100 + 64'(2 * i + 1), 7'h30, 7'h31, 1'b0, 1'b1);
            step_clr();
        end
        check("full_free_cnt", free_cnt, 0);
        step();
        check("full_hold", free_cnt, 0);
        set_wake(0, 7'h30);
        for (int k = 0; k < 8; k++)
            exp_iss(cyc + 1 + k, 2, 64'h100 + 64'(2 * k), 2 * k, 64'h100 + 64'(2 * k + 1), 2 * k + 1);
        step_clr();
        check("full_after_wake", free_cnt, 0);
        repeat (9) step();
        check("full_drained", free_cnt, 16);

        // Entry 0 is recycled while entries 1..3 still wait; priority depends on the age option.
        set_disp(0, 64'h200, 7'h01, 7'h02, 1'b1, 1'b1);
        set_disp(1, 64'h201, 7'h40, 7'h41, 1'b0, 1'b1);
        exp_iss(cyc + 1, 1, 64'h200, 0, 64'h0, 0);
        step_clr();
        set_disp(0, 64'h202, 7'h40, 7'h41, 1'b0, 1'b1);
        set_disp(1, 64'h203, 7'h40, 7'h41, 1'b0, 1'b1);
        step_clr();
        step();
        set_disp(0, 64'hE, 7'h40, 7'h41, 1'b0, 1'b1);
        step_clr();
        set_wake(0, 7'h40);
`ifdef SCARIV_ISSUE_OLDEST_EN
        exp_iss(cyc + 1, 2, 64'h201, 1, 64'h202, 2);
        exp_iss(cyc + 2, 2, 64'h203, 3, 64'hE, 0);
`else
        exp_iss(cyc + 1, 2, 64'hE, 0, 64'h201, 1);
        exp_iss(cyc + 2, 2, 64'h202, 2, 64'h203, 3);
`endif
        step_clr();
        repeat (3) step();
        check("recycle_drained", free_cnt, 16);

        // Flush with five waiting entries and a ready op dispatched in the same cycle.
        set_disp(0, 64'h500, 7'h50, 7'h51, 1'b0, 1'b1);
        set_disp(1, 64'h501, 7'h50, 7'h51, 1'b0, 1'b1);
        step_clr();
        set_disp(0, 64'h502, 7'h50, 7'h51, 1'b0, 1'b1);
        set_disp(1, 64'h503, 7'h50, 7'h51, 1'b0, 1'b1);
        step_clr();
        set_disp(0, 64'h504, 7'h50, 7'h51, 1'b0, 1'b1);
        step_clr();
        check("pre_flush_free", free_cnt, 11);
        flush = 1'b1;
        set_disp(0, 64'h300, 7'h01, 7'h02, 1'b1, 1'b1);
        exp_iss(cyc + 1, 0, 64'h0, 0, 64'h0, 0);
        step_clr();
        check("flush_free_cnt", free_cnt, 16);
        set_wake(0, 7'h50);
        step_clr();
        step();

        // Asynchronous reset while two ops are on the issue ports.
        set_disp(0, 64'h400, 7'h01, 7'h02, 1'b1, 1'b1);
        set_disp(1, 64'h401, 7'h01, 7'h02, 1'b1, 1'b1);
        step_clr();
        check("pre_rst_valid", iss_valid, 2'b11);
        check("pre_rst_payload0", iss_payload[0], 64'h400);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", iss_valid, 0);
        check("async_rst_payload0", iss_payload[0], 0);
        check("async_rst_index0", iss_index_oh[0], 0);
        check("async_rst_free_cnt", free_cnt, 16);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_free_cnt", free_cnt, 16);
        check("sb_empty", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
